// File: rtl/ring_chk_pkg.sv
// Shared types and helpers for the one-hot ring-sequence checker.
package ring_chk_pkg;

    localparam int unsigned MAX_W = 32;

    typedef enum logic [1:0] {
        SEEK  = 2'b00,
        TRACK = 2'b01,
        PASS  = 2'b10,
        FAIL  = 2'b11
    } chk_state_e;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_SEQ  = 2'b01;
    localparam logic [1:0] CAUSE_TMO  = 2'b10;

    // Rotate the low w bits of x left by one; bits above w are returned as zero.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int unsigned w);
        logic [MAX_W-1:0] mask;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        return ((x << 1) | ((x & mask) >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_chk_sync_filter.sv
// Two-flop synchroniser followed by a stability filter; pulses acc_evt when a new
// value has been seen for STABLE_CYCLES consecutive synchronised samples.
module ring_chk_sync_filter
    import ring_chk_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pat_in,
    output logic [WIDTH-1:0] acc,
    output logic             acc_evt
);

    localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0]  meta_q, meta_d;
    logic [WIDTH-1:0]  sync_q, sync_d;
    logic [WIDTH-1:0]  cand_q, cand_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              evt_q, evt_d;

    // The count is judged on its updated value so acceptance lands on the
    // STABLE_CYCLES-th identical sample (a clean change is seen 2+STABLE_CYCLES later).
    always_comb begin
        meta_d = pat_in;
        sync_d = meta_q;
        cand_d = cand_q;
        stab_d = stab_q;
        acc_d  = acc_q;
        evt_d  = 1'b0;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            stab_d = '0;
        end else if (stab_q != STAB_W'(STABLE_CYCLES)) begin
            stab_d = stab_q + STAB_W'(1);
        end
        if ((stab_d == STAB_W'(STABLE_CYCLES - 1)) && (cand_d != acc_q)) begin
            acc_d = cand_d;
            evt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            cand_q <= '0;
            stab_q <= '0;
            acc_q  <= '0;
            evt_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            cand_q <= cand_d;
            stab_q <= stab_d;
            acc_q  <= acc_d;
            evt_q  <= evt_d;
        end
    end

    assign acc     = acc_q;
    assign acc_evt = evt_q;

endmodule

// File: rtl/ring_seq_checker.sv
// Locks onto a one-hot ring pattern from the pads and checks that every accepted
// change is a single left rotation; reports a sticky pass/fail with diagnostics.
module ring_seq_checker
    import ring_chk_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned LAPS          = 2,
    parameter int unsigned TIMEOUT       = 4096,
    parameter int unsigned LAP_W         = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] pat_in,
    output logic             pass,
    output logic             fail,
    output logic [1:0]       fail_cause,
    output logic [WIDTH-1:0] bad_pat,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [1:0]       state_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [WIDTH-1:0] START = WIDTH'(1);

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
        return WIDTH'(rotl(MAX_W'(x), WIDTH));
    endfunction

    logic [WIDTH-1:0] acc;
    logic             acc_evt;

    ring_chk_sync_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .pat_in  (pat_in),
        .acc     (acc),
        .acc_evt (acc_evt)
    );

    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [LAP_W-1:0] lap_q, lap_d;
    logic [LAP_W-1:0] lap_inc;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [1:0]       cause_q, cause_d;
    logic [WIDTH-1:0] bad_q, bad_d;
    logic             en_q, en_d;

    assign lap_inc = (lap_q == '1) ? lap_q : lap_q + LAP_W'(1);

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        tmo_d   = tmo_q;
        lap_d   = lap_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        cause_d = cause_q;
        bad_d   = bad_q;
        en_d    = en;
        if (clr || !en) begin
            state_d = SEEK;
            tmo_d   = '0;
            lap_d   = '0;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            cause_d = CAUSE_NONE;
            bad_d   = '0;
        end else begin
            case (state_q)
                // Lock on a fresh start pattern, or on one already present when en rises.
                SEEK: begin
                    if ((acc == START) && (acc_evt || !en_q)) begin
                        state_d = TRACK;
                        exp_d   = rot(START);
                        tmo_d   = '0;
                        lap_d   = '0;
                    end
                end
                TRACK: begin
                    tmo_d = tmo_q + TMO_W'(1);
                    if (acc_evt) begin
                        if (acc == exp_q) begin
                            exp_d = rot(acc);
                            tmo_d = '0;
                            if (acc == START) begin
                                lap_d = lap_inc;
                                if (lap_inc == LAP_W'(LAPS)) begin
                                    state_d = PASS;
                                    pass_d  = 1'b1;
                                end
                            end
                        end else begin
                            state_d = FAIL;
                            fail_d  = 1'b1;
                            cause_d = CAUSE_SEQ;
                            bad_d   = acc;
                        end
                    end else if (tmo_d == TMO_W'(TIMEOUT - 1)) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        cause_d = CAUSE_TMO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= SEEK;
            exp_q   <= '0;
            tmo_q   <= '0;
            lap_q   <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            cause_q <= CAUSE_NONE;
            bad_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            tmo_q   <= tmo_d;
            lap_q   <= lap_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            cause_q <= cause_d;
            bad_q   <= bad_d;
            en_q    <= en_d;
        end
    end

    assign pass       = pass_q;
    assign fail       = fail_q;
    assign fail_cause = cause_q;
    assign bad_pat    = bad_q;
    assign lap_cnt    = lap_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Directed bench for ring_seq_checker with WIDTH=4, STABLE_CYCLES=4, LAPS=2, TIMEOUT=64.
module tb_ring_seq_checker;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic       en;
    logic       clr;
    logic [3:0] pat_in;
    logic       pass;
    logic       fail;
    logic [1:0] fail_cause;
    logic [3:0] bad_pat;
    logic [7:0] lap_cnt;
    logic [1:0] state_o;

    int n_vec  = 0;
    int n_miss = 0;
    int n_cyc;

    ring_seq_checker #(
        .WIDTH         (4),
        .STABLE_CYCLES (4),
        .LAPS          (2),
        .TIMEOUT       (64),
        .LAP_W         (8)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .en         (en),
        .clr        (clr),
        .pat_in     (pat_in),
        .pass       (pass),
        .fail       (fail),
        .fail_cause (fail_cause),
        .bad_pat    (bad_pat),
        .lap_cnt    (lap_cnt),
        .state_o    (state_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".state"}, 32'(state_o), 32'h0);
        check({tag, ".pass"}, 32'(pass), 32'h0);
        check({tag, ".fail"}, 32'(fail), 32'h0);
        check({tag, ".cause"}, 32'(fail_cause), 32'h0);
        check({tag, ".bad"}, 32'(bad_pat), 32'h0);
        check({tag, ".lap"}, 32'(lap_cnt), 32'h0);
    endtask

    task automatic hold(input logic [3:0] p, input int n);
        pat_in = p;
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        wb_rst_i = 1'b1;
        pat_in   = 4'b0000;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
    endtask

    // Edges from now until the chosen flag rises; returns bound if it never does.
    task automatic cycles_to(input bit want_pass, input int bound, output int n);
        n = 0;
        while (n < bound) begin
            @(posedge wb_clk_i);
            #1;
            n++;
            if (want_pass ? pass : fail) break;
        end
    endtask

    initial begin
        en  = 1'b0;
        clr = 1'b0;
        do_reset();
        check_idle("reset");

        // Clean two-lap sequence
        en = 1'b1;
        hold(4'b0001, 10);
        check("clean.lock", 32'(state_o), 32'h1);
        hold(4'b0010, 10);
        hold(4'b0100, 10);
        hold(4'b1000, 10);
        hold(4'b0001, 10);
        check("clean.lap1", 32'(lap_cnt), 32'h1);
        hold(4'b0010, 10);
        hold(4'b0100, 10);
        hold(4'b1000, 10);
        check("clean.nopass", 32'(pass), 32'h0);
        pat_in = 4'b0001;
        cycles_to(1'b1, 30, n_cyc);
        check("clean.pass_lat", 32'(n_cyc), 32'd7);
        check("clean.state", 32'(state_o), 32'h2);
        check("clean.fail", 32'(fail), 32'h0);
        check("clean.lap2", 32'(lap_cnt), 32'h2);
        hold(4'b0100, 10);
        check("clean.sticky", 32'(pass), 32'h1);

        // Skipped step
        do_reset();
        hold(4'b0001, 10);
        hold(4'b0010, 10);
        hold(4'b1000, 10);
        check("bad.fail", 32'(fail), 32'h1);
        check("bad.cause", 32'(fail_cause), 32'h1);
        check("bad.pat", 32'(bad_pat), 32'h8);
        check("bad.pass", 32'(pass), 32'h0);
        check("bad.state", 32'(state_o), 32'h3);

        clr = 1'b1;
        @(posedge wb_clk_i);
        #1;
        clr = 1'b0;
        check_idle("clr");

        // Short glitch rejected, long one accepted and flagged
        do_reset();
        hold(4'b0001, 10);
        hold(4'b0110, 2);
        hold(4'b0010, 10);
        check("glitch.fail", 32'(fail), 32'h0);
        check("glitch.state", 32'(state_o), 32'h1);
        hold(4'b0100, 10);
        check("glitch.cont", 32'(state_o), 32'h1);
        hold(4'b0110, 4);
        hold(4'b1000, 10);
        check("glitch4.fail", 32'(fail), 32'h1);
        check("glitch4.cause", 32'(fail_cause), 32'h1);
        check("glitch4.pat", 32'(bad_pat), 32'h6);

        // Timeout: 6 cycles to accept 0010, then 64 cycles with no change
        do_reset();
        hold(4'b0001, 10);
        pat_in = 4'b0010;
        cycles_to(1'b0, 200, n_cyc);
        check("tmo.lat", 32'(n_cyc), 32'd70);
        check("tmo.cause", 32'(fail_cause), 32'h2);
        check("tmo.bad", 32'(bad_pat), 32'h0);
        check("tmo.pass", 32'(pass), 32'h0);

        // Lock only on the start pattern
        do_reset();
        hold(4'b0100, 10);
        check("lock.0100", 32'(state_o), 32'h0);
        hold(4'b1000, 10);
        check("lock.1000", 32'(state_o), 32'h0);
        hold(4'b0001, 10);
        check("lock.state", 32'(state_o), 32'h1);
        check("lock.lap", 32'(lap_cnt), 32'h0);
        hold(4'b0010, 10);
        hold(4'b0100, 10);
        hold(4'b1000, 10);
        hold(4'b0001, 10);
        check("lock.lap1", 32'(lap_cnt), 32'h1);

        // en low mid-TRACK, then relock on en rising with start already present
        en = 1'b0;
        @(posedge wb_clk_i);
        #1;
        check("en.state", 32'(state_o), 32'h0);
        check("en.lap", 32'(lap_cnt), 32'h0);
        check("en.fail", 32'(fail), 32'h0);
        en = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("en.relock", 32'(state_o), 32'h1);

        // Reset mid-TRACK
        hold(4'b0010, 10);
        check("rst.pre", 32'(state_o), 32'h1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check_idle("rst_mid");
        wb_rst_i = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ring_seq_checker.md
Name: ring_seq_checker

Overview:
- On-chip checker for a WIDTH-bit one-hot ring-counter pattern arriving on user GPIO inputs (e.g. mprj_io[11:8] looped back or driven from off-chip).
- Synchronises and de-glitches the pattern, then locks onto the start pattern.
- Verifies every subsequent change is a single left rotation.
- Reports sticky pass/fail plus diagnostics to logic analyzer probes / GPIO outputs in the user project wrapper.

Parameters:
- WIDTH, 4, pattern width; start pattern is one-hot with bit 0 set.
- STABLE_CYCLES, 4, consecutive identical synchronised samples required to accept a value (minimum 1).
- LAPS, 2, full rotations (return to start) required for pass.
- TIMEOUT, 4096, maximum cycles between accepted changes while tracking.
- LAP_W, 8, width of lap counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- en  in  1  check enable; low forces SEEK and clears counters.
- clr  in  1  clears sticky result and returns to SEEK.
- pat_in  in  WIDTH  asynchronous pattern from pads.
- pass  out  1  sticky pass.
- fail  out  1  sticky fail.
- fail_cause  out  2  00 none, 01 bad sequence, 10 timeout.
- bad_pat  out  WIDTH  accepted pattern that caused a sequence fail; 0 otherwise.
- lap_cnt  out  LAP_W  completed rotations since lock.
- state_o  out  2  00 SEEK, 01 TRACK, 10 PASS, 11 FAIL.

Behaviour:
- Reset: all outputs 0, state SEEK, internal acc/cand/counters 0.
- Front end:
  - 2-flop synchroniser gives sync.
  - cand register loads sync whenever sync != cand, and stab_cnt is cleared.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
  - When stab_cnt == STABLE_CYCLES-1 and cand != acc: acc <= cand and acc_evt pulses for 1 cycle.
  - Latency: a clean pat_in change produces acc_evt 2+STABLE_CYCLES cycles later.
- SEEK:
  - Ignore acc_evt unless acc == start (1).
  - Also lock if acc already equals start when en rises.
  - On lock: go to TRACK, expected <= rotl(start), tmo_cnt <= 0, lap_cnt <= 0.
- TRACK:
  - tmo_cnt increments each cycle.
  - On acc_evt:
    - If acc == expected: expected <= rotl(acc); tmo_cnt <= 0.
    - If acc == start, lap_cnt++. If the new lap_cnt == LAPS, go to PASS.
    - If acc != expected (zero, multi-hot, skip, reverse): go to FAIL, fail_cause=01, bad_pat=acc.
  - tmo_cnt reaching TIMEOUT-1 with no acc_evt: go to FAIL, fail_cause=10.
  - acc_evt and timeout in the same cycle: acc_evt wins.
- PASS / FAIL:
  - Sticky; pass/fail are registered, asserted the cycle after the deciding acc_evt or timeout.
  - Ignore further pattern changes.
  - Exactly one of pass/fail is ever high.
- Priority: wb_rst_i > clr > en low > FSM.
  - clr or en low: state SEEK; pass, fail, fail_cause, bad_pat, lap_cnt, tmo_cnt cleared. The front end keeps running.
  - en low mid-TRACK is not a failure.
- Reset mid-operation restores full reset state on the next edge.
- Rotation: rotl(x) = {x[WIDTH-2:0], x[WIDTH-1]}; the 1000 -> 0001 wrap is legal.
- Counters:
  - lap_cnt saturates at all-ones.
  - tmo_cnt width is clog2(TIMEOUT).

Decomposition:
- Package ring_chk_pkg:
  - state enum (SEEK/TRACK/PASS/FAIL, 2-bit encoding above).
  - cause constants CAUSE_NONE/SEQ/TMO.
  - rotl function.
- Sub-module ring_chk_sync_filter (synchroniser + stability filter; outputs acc, acc_evt).
- FSM and counters in the top module.

Test Plan:
- All tests use WIDTH=4, STABLE_CYCLES=4, LAPS=2, TIMEOUT=64.
- Clean sequence: en=1; drive 0001, 0010, 0100, 1000 twice, then 0001, each held 10 cycles -> lap_cnt reaches 2, pass=1 exactly 7 cycles after the final 0001 edge, state_o=10, fail=0.
- Bad step: lock on 0001, then drive 0010, 1000 -> fail=1, fail_cause=01, bad_pat=1000, pass never asserts.
- Glitch rejection:
  - 0001 -> 0010 with a 2-cycle pulse of 0110 between -> no fail, sequence continues.
  - A 4-cycle hold of 0110 -> fail_cause=01, bad_pat=0110.
- Timeout: lock on 0001, hold 0010 indefinitely -> fail=1, fail_cause=10, 64 cycles after the 0010 acc_evt.
- Lock behaviour: drive 0100, 1000 before 0001 -> state_o stays 00. Then 0001 -> state_o=01, lap_cnt=0.
- Clear/enable/reset:
  - clr asserted in FAIL -> next cycle all outputs 0, state SEEK.
  - en dropped mid-TRACK -> SEEK, lap_cnt=0, fail=0.
  - wb_rst_i pulsed mid-TRACK -> all outputs 0 on the next edge.
